data_memory_lsu: RTL and testbench

Parametrised, byte-addressed data memory with a load/store front end, for the CPU datapath. Adds several features to the plain word-array memory:
- byte, halfword, word and (64-bit) doubleword access
- byte-lane write merging
- sign/zero-extending loads
- alignment checking
- valid/ready request and response handshakes
- configurable synchronous read latency

It serves one outstanding load at a time.

---
 rtl/dmem_pkg.sv | 51 +++++
 rtl/dmem_array.sv | 25 ++
 rtl/data_memory_lsu.sv | 138 +++++++++++++
 tb/tb_data_memory_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM
// states, byte-lane mask, alignment check and load extension helpers.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Byte enables for an access of the given size starting at a byte lane;
  // callers truncate to their own lane count.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      SIZE_WORD: base = 8'h0F;
      default:   base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [2:0] addr_lo,
                                    input logic dword_ok);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return addr_lo[0] == 1'b0;
      SIZE_WORD: return addr_lo[1:0] == 2'b00;
      default:   return dword_ok && (addr_lo == 3'b000);
    endcase
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] word, input logic [2:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: return {{56{sgn & sh[7]}},  sh[7:0]};
      SIZE_HALF: return {{48{sgn & sh[15]}}, sh[15:0]};
      SIZE_WORD: return {{32{sgn & sh[31]}}, sh[31:0]};
      default:   return sh;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port RAM with a registered (synchronous) read port.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**IDX_W];

  // NOTE: the storage array has no reset so it maps onto RAM macros; its
  // contents deliberately survive rstN.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with valid/ready load/store front end.
// Optional store acknowledge responses: define DMEM_WRITE_ACK_EN.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [1:0]            reqSize,
  input  logic                  reqSigned,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [DATA_WIDTH-1:0] reqData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic                  rspErr,
  output logic                  storeErr
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_WIDTH - LANE_W;

  state_t state, state_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic [IDX_W-1:0]  idx_q;
  logic [LANE_W-1:0] lane_q;
  logic [1:0]        size_q;
  logic              sgn_q, err_q, load_q;

  logic [IDX_W-1:0]      req_idx, arr_idx;
  logic [LANE_W-1:0]     req_lane;
  logic                  req_fire, req_legal, arr_we;
  logic [NBYTES-1:0]     arr_be;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;

  assign req_idx   = reqAddr[ADDR_WIDTH-1:LANE_W];
  assign req_lane  = reqAddr[LANE_W-1:0];
  assign req_fire  = reqValid && reqReady;
  assign req_legal = is_legal(reqSize, reqAddr[2:0], DATA_WIDTH == 64);

  // Stores are dropped while rstN is low even though the FSM sits in IDLE.
  assign arr_we    = req_fire && reqWrite && req_legal && rstN;
  assign arr_be    = NBYTES'(lane_mask(reqSize, 3'(req_lane)));
  assign arr_wdata = reqData << {req_lane, 3'b000};

  // Hold the captured index after acceptance so rdata re-reads the same word
  // (no store can land meanwhile), keeping the response stable under stall.
  assign arr_idx = (state == ST_IDLE) ? req_idx : idx_q;

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .be   (arr_be),
    .idx  (arr_idx),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      size_q   <= SIZE_BYTE;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
      storeErr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_fire) begin
        idx_q  <= req_idx;
        lane_q <= req_lane;
        size_q <= reqSize;
        sgn_q  <= reqSigned;
        err_q  <= !req_legal;
        load_q <= !reqWrite;
      end
      if (req_fire && reqWrite && !req_legal) storeErr <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    reqReady  = 1'b0;
    rspValid  = 1'b0;
    case (state)
      ST_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) begin
          if (reqWrite) begin
`ifdef DMEM_WRITE_ACK_EN
            state_nxt = ST_RESP;
`endif
          end else if (READ_LATENCY == 1) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 2'(READ_LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 2'd1) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 2'd1;
      end
      ST_RESP: begin
        rspValid = 1'b1;
        if (rspReady) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign rspErr  = (state == ST_RESP) && err_q;
  assign rspData = (state == ST_RESP && load_q && !err_q)
                 ? DATA_WIDTH'(extend_load(64'(arr_rdata), 3'(lane_q), size_q, sgn_q))
                 : '0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: three instances (32b/L1, 32b/L3, 64b/L2)
// share the request bus; sel picks which one is driven and observed.
module tb_data_memory_lsu;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel = 2'd0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [11:0] req_addr = '0;
  logic [63:0] req_data = '0;

  logic        req_ready, rsp_valid, rsp_err, store_err;
  logic [63:0] rsp_data;
  logic [2:0]  rdy, vld, err, serr;
  logic [31:0] dat_a, dat_b;
  logic [63:0] dat_c;

  int total = 0;
  int bad = 0;

  data_memory_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(1)) u_a (
    .clk(clk), .rstN(rst_n), .reqValid(req_valid && sel == 2'd0), .reqReady(rdy[0]),
    .reqWrite(req_write), .reqSize(req_size), .reqSigned(req_signed), .reqAddr(req_addr),
    .reqData(req_data[31:0]), .rspValid(vld[0]), .rspReady(rsp_ready), .rspData(dat_a),
    .rspErr(err[0]), .storeErr(serr[0]));

  data_memory_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(3)) u_b (
    .clk(clk), .rstN(rst_n), .reqValid(req_valid && sel == 2'd1), .reqReady(rdy[1]),
    .reqWrite(req_write), .reqSize(req_size), .reqSigned(req_signed), .reqAddr(req_addr),
    .reqData(req_data[31:0]), .rspValid(vld[1]), .rspReady(rsp_ready), .rspData(dat_b),
    .rspErr(err[1]), .storeErr(serr[1]));

  data_memory_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .READ_LATENCY(2)) u_c (
    .clk(clk), .rstN(rst_n), .reqValid(req_valid && sel == 2'd2), .reqReady(rdy[2]),
    .reqWrite(req_write), .reqSize(req_size), .reqSigned(req_signed), .reqAddr(req_addr),
    .reqData(req_data), .rspValid(vld[2]), .rspReady(rsp_ready), .rspData(dat_c),
    .rspErr(err[2]), .storeErr(serr[2]));

  always_comb begin
    req_ready = rdy[sel];
    rsp_valid = vld[sel];
    rsp_err   = err[sel];
    store_err = serr[sel];
    case (sel)
      2'd0:    rsp_data = {32'h0, dat_a};
      2'd1:    rsp_data = {32'h0, dat_b};
      default: rsp_data = dat_c;
    endcase
  end

  // Present one request at a negedge and return 1ns after the accepting edge.
  task automatic send_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [11:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_data = d;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_accept_timeout sel=%0d addr=%h", sel, a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [63:0] d, output logic e);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout sel=%0d", sel);
    end
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic e;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      #1;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
          store_err !== 1'b0 || rsp_data !== 64'h0) begin
        bad++;
        $display("FAIL reset_state sel=%0d ready=%b valid=%b err=%b serr=%b data=%h want 1 0 0 0 0",
                 sel, req_ready, rsp_valid, rsp_err, store_err, rsp_data);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    sel = 2'd1;
    send_req(1'b1, SIZE_WORD, 1'b0, 12'h010, 64'hDEADBEEF);
    send_req(1'b0, SIZE_WORD, 1'b0, 12'h010, 64'h0);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL l3_early_valid got=%b want 0", rsp_valid);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_wait valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_req(1'b0, SIZE_WORD, 1'b0, 12'h010, 64'h0);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL l3_valid_edge0 got=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL l3_valid_edge1 got=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL l3_valid_edge2 got=%b want 1", rsp_valid);
    end
    get_rsp(d, e);
    total++;
    if (d !== 64'hDEADBEEF || e !== 1'b0) begin
      bad++; $display("FAIL reset_keeps_mem data=%h err=%b want deadbeef 0", d, e);
    end
  endtask

  task automatic test_merge();
    logic [63:0] d;
    logic e;
    sel = 2'd0;
    send_req(1'b1, SIZE_WORD, 1'b0, 12'h020, 64'h11223344);
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL store_posted_ready got=%b want 1", req_ready);
    end
    send_req(1'b1, SIZE_BYTE, 1'b0, 12'h021, 64'hAA);
    send_req(1'b0, SIZE_WORD, 1'b0, 12'h020, 64'h0);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL l1_latency valid=%b want 1", rsp_valid);
    end
    get_rsp(d, e);
    total++;
    if (d !== 64'h1122AA44 || e !== 1'b0) begin
      bad++; $display("FAIL byte_merge data=%h err=%b want 1122aa44 0", d, e);
    end
  endtask

  task automatic test_extend();
    logic [63:0] d;
    logic e;
    logic [1:0]  sz  [4] = '{SIZE_HALF, SIZE_HALF, SIZE_BYTE, SIZE_BYTE};
    logic        sg  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] ad  [4] = '{12'h040, 12'h040, 12'h041, 12'h040};
    logic [63:0] exp [4] = '{64'hFFFF80F0, 64'h000080F0, 64'hFFFFFF80, 64'h000000F0};
    sel = 2'd0;
    send_req(1'b1, SIZE_HALF, 1'b0, 12'h040, 64'h000080F0);
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, sz[i], sg[i], ad[i], 64'h0);
      get_rsp(d, e);
      total++;
      if (d !== exp[i] || e !== 1'b0) begin
        bad++;
        $display("FAIL extend_%0d data=%h err=%b want %h 0", i, d, e, exp[i]);
      end
    end
  endtask

  task automatic test_align();
    logic [63:0] d;
    logic e;
    sel = 2'd0;
    send_req(1'b0, SIZE_WORD, 1'b0, 12'h022, 64'h0);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL misaligned_latency valid=%b want 1", rsp_valid);
    end
    get_rsp(d, e);
    total++;
    if (d !== 64'h0 || e !== 1'b1) begin
      bad++; $display("FAIL misaligned_load data=%h err=%b want 0 1", d, e);
    end
    total++;
    if (store_err !== 1'b0) begin
      bad++; $display("FAIL store_err_clear got=%b want 0", store_err);
    end
    send_req(1'b1, SIZE_HALF, 1'b0, 12'h023, 64'hBEEF);
    total++;
    if (store_err !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL misaligned_store serr=%b ready=%b want 1 1", store_err, req_ready);
    end
    send_req(1'b0, SIZE_WORD, 1'b0, 12'h020, 64'h0);
    get_rsp(d, e);
    total++;
    if (d !== 64'h1122AA44 || e !== 1'b0) begin
      bad++; $display("FAIL mem_unchanged data=%h err=%b want 1122aa44 0", d, e);
    end
    send_req(1'b0, SIZE_BYTE, 1'b0, 12'h023, 64'h0);
    get_rsp(d, e);
    total++;
    if (d !== 64'h11 || e !== 1'b0) begin
      bad++; $display("FAIL odd_byte_load data=%h err=%b want 11 0", d, e);
    end
    send_req(1'b0, SIZE_DWORD, 1'b0, 12'h020, 64'h0);
    get_rsp(d, e);
    total++;
    if (d !== 64'h0 || e !== 1'b1 || store_err !== 1'b1) begin
      bad++;
      $display("FAIL dword_on_32 data=%h err=%b serr=%b want 0 1 1", d, e, store_err);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic e;
    sel = 2'd0;
    @(negedge clk);
    req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0; req_addr = 12'h020;
    req_valid = 1'b1; rsp_ready = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_idle_ready got=%b want 1", req_ready);
    end
    @(posedge clk); #1;
    // Next request stays pending with different fields while the first stalls.
    req_size = SIZE_HALF; req_addr = 12'h040;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 64'h1122AA44 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d valid=%b data=%h ready=%b want 1 1122aa44 0",
                 k, rsp_valid, rsp_data, req_ready);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_consume valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1; req_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h80F0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_load valid=%b data=%h err=%b want 1 80f0 0",
               rsp_valid, rsp_data, rsp_err);
    end
    get_rsp(d, e);
  endtask

  task automatic test_dword();
    logic [63:0] d;
    logic e;
    logic [1:0]  sz  [4] = '{SIZE_WORD, SIZE_WORD, SIZE_HALF, SIZE_DWORD};
    logic        sg  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [11:0] ad  [4] = '{12'h008, 12'h00C, 12'h00E, 12'h00C};
    logic [63:0] exp [4] = '{64'hFFFFFFFF89ABCDEF, 64'h0000000001234567, 64'h0123, 64'h0};
    logic        xer [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    sel = 2'd2;
    send_req(1'b1, SIZE_DWORD, 1'b0, 12'h008, 64'h0123456789ABCDEF);
    send_req(1'b0, SIZE_DWORD, 1'b0, 12'h008, 64'h0);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL l2_valid_edge0 got=%b want 0", rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h0123456789ABCDEF || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL dword_load valid=%b data=%h err=%b want 1 0123456789abcdef 0",
               rsp_valid, rsp_data, rsp_err);
    end
    get_rsp(d, e);
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, sz[i], sg[i], ad[i], 64'h0);
      get_rsp(d, e);
      total++;
      if (d !== exp[i] || e !== xer[i]) begin
        bad++;
        $display("FAIL dw_sub_%0d data=%h err=%b want %h %b", i, d, e, exp[i], xer[i]);
      end
    end
    send_req(1'b1, SIZE_BYTE, 1'b0, 12'h00F, 64'h5A);
    send_req(1'b0, SIZE_DWORD, 1'b0, 12'h008, 64'h0);
    get_rsp(d, e);
    total++;
    if (d !== 64'h5A23456789ABCDEF || e !== 1'b0) begin
      bad++; $display("FAIL dw_lane7_merge data=%h err=%b want 5a23456789abcdef 0", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_merge();
    test_extend();
    test_align();
    test_backpressure();
    test_dword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

endmodule
